// File: rtl/clct_pretrig_hold_if.sv
// Bus between the best-1-of-32 sorter/config side (master) and the pre-trigger hold stage (slave).
interface clct_pretrig_hold_if #(
  parameter int MXPATB = 7,
  parameter int MXKEYB = 5,
  parameter int MXPATC = 4,
  parameter int MXCNTB = 16
);
  logic [MXPATB-1:0] best_pat;
  logic [MXKEYB-1:0] best_key;
  logic [MXPATC-1:0] best_carry;
  logic [2:0]        hit_thresh;
  logic [3:0]        pid_thresh;
  logic [3:0]        drift_delay;
  logic [3:0]        dead_time;
  logic              cnt_clear;

  logic              pretrig;
  logic              busy;
  logic              clct_vld;
  logic [MXPATB-1:0] clct_pat;
  logic [MXKEYB-1:0] clct_key;
  logic [MXPATC-1:0] clct_carry;
  logic [MXCNTB-1:0] pretrig_cnt;

  modport master (
    output best_pat, best_key, best_carry, hit_thresh, pid_thresh,
           drift_delay, dead_time, cnt_clear,
    input  pretrig, busy, clct_vld, clct_pat, clct_key, clct_carry, pretrig_cnt
  );

  modport slave (
    input  best_pat, best_key, best_carry, hit_thresh, pid_thresh,
           drift_delay, dead_time, cnt_clear,
    output pretrig, busy, clct_vld, clct_pat, clct_key, clct_carry, pretrig_cnt
  );
endinterface

// File: rtl/clct_pretrig_hold.sv
// CLCT pre-trigger: qualifies the sorter's best pattern, holds it through a drift window
// (upgrading on a strictly better same-key pattern), emits once, then enforces dead time.
module clct_pretrig_hold #(
  parameter int MXPATB = 7,
  parameter int MXKEYB = 5,
  parameter int MXPATC = 4,
  parameter int MXCNTB = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  clct_pretrig_hold_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRIFT = 2'd1, DEAD = 2'd2} state_t;

  state_t            state_q,       state_d;
  logic [3:0]        cnt_q,         cnt_d;
  logic [MXPATB-1:0] hold_pat_q,    hold_pat_d;
  logic [MXKEYB-1:0] hold_key_q,    hold_key_d;
  logic [MXPATC-1:0] hold_carry_q,  hold_carry_d;
  logic              pretrig_q,     pretrig_d;
  logic              busy_q,        busy_d;
  logic              clct_vld_q,    clct_vld_d;
  logic [MXPATB-1:0] clct_pat_q,    clct_pat_d;
  logic [MXKEYB-1:0] clct_key_q,    clct_key_d;
  logic [MXPATC-1:0] clct_carry_q,  clct_carry_d;
  logic [MXCNTB-1:0] pretrig_cnt_q, pretrig_cnt_d;

  logic qualify;
  logic upgrade;

  always_comb begin
    qualify = (bus.best_pat[MXPATB-1:4] >= bus.hit_thresh) &&
              (bus.best_pat[3:0] >= bus.pid_thresh);
    // Bend bit (bit 0) does not make a pattern better.
    upgrade = (bus.best_key == hold_key_q) &&
              (bus.best_pat[MXPATB-1:1] > hold_pat_q[MXPATB-1:1]);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_pat_d   = hold_pat_q;
    hold_key_d   = hold_key_q;
    hold_carry_d = hold_carry_q;
    pretrig_d    = 1'b0;
    busy_d       = 1'b0;
    clct_vld_d   = 1'b0;
    clct_pat_d   = clct_pat_q;
    clct_key_d   = clct_key_q;
    clct_carry_d = clct_carry_q;

    unique case (state_q)
      IDLE: begin
        if (qualify) begin
          hold_pat_d   = bus.best_pat;
          hold_key_d   = bus.best_key;
          hold_carry_d = bus.best_carry;
          cnt_d        = bus.drift_delay;
          state_d      = DRIFT;
          pretrig_d    = 1'b1;
          busy_d       = 1'b1;
        end
      end
      DRIFT: begin
        if (upgrade) begin
          hold_pat_d   = bus.best_pat;
          hold_key_d   = bus.best_key;
          hold_carry_d = bus.best_carry;
        end
        if (cnt_q != 4'd0) begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end else begin
          // Emit includes an upgrade taken on this final drift cycle.
          clct_vld_d   = 1'b1;
          clct_pat_d   = hold_pat_d;
          clct_key_d   = hold_key_d;
          clct_carry_d = hold_carry_d;
          if (bus.dead_time != 4'd0) begin
            cnt_d   = bus.dead_time;
            state_d = DEAD;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DEAD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = IDLE;
        else               busy_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pretrig_cnt_d = pretrig_cnt_q;
    if (bus.cnt_clear)
      pretrig_cnt_d = '0;
    else if (pretrig_q && (pretrig_cnt_q != {MXCNTB{1'b1}}))
      pretrig_cnt_d = pretrig_cnt_q + MXCNTB'(1);
  end

  // NOTE: every register, held pattern included, is cleared by reset so an aborted window leaves no trace.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hold_pat_q    <= '0;
      hold_key_q    <= '0;
      hold_carry_q  <= '0;
      pretrig_q     <= 1'b0;
      busy_q        <= 1'b0;
      clct_vld_q    <= 1'b0;
      clct_pat_q    <= '0;
      clct_key_q    <= '0;
      clct_carry_q  <= '0;
      pretrig_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_pat_q    <= hold_pat_d;
      hold_key_q    <= hold_key_d;
      hold_carry_q  <= hold_carry_d;
      pretrig_q     <= pretrig_d;
      busy_q        <= busy_d;
      clct_vld_q    <= clct_vld_d;
      clct_pat_q    <= clct_pat_d;
      clct_key_q    <= clct_key_d;
      clct_carry_q  <= clct_carry_d;
      pretrig_cnt_q <= pretrig_cnt_d;
    end
  end

  assign bus.pretrig     = pretrig_q;
  assign bus.busy        = busy_q;
  assign bus.clct_vld    = clct_vld_q;
  assign bus.clct_pat    = clct_pat_q;
  assign bus.clct_key    = clct_key_q;
  assign bus.clct_carry  = clct_carry_q;
  assign bus.pretrig_cnt = pretrig_cnt_q;

endmodule

// File: doc/clct_pretrig_hold.md
Name: clct_pretrig_hold

Overview:
- Sits directly downstream of the best-1-of-32 pattern sorter.
- Each clock it receives one best pattern word, key and carry, and tests it against hit and pattern-ID thresholds.
- A passing candidate fires a pre-trigger and is held through a programmable drift window. During that window it is replaced by a strictly better pattern on the same key.
- At the end of the window the held result is emitted once, followed by a programmable dead time.

Parameters:
- MXPATB, 7, pattern word width. Bits [6:4] are the hit count, bits [3:0] the pattern ID. Bit 0 is the bend direction.
- MXKEYB, 5, key width (1 of 32).
- MXPATC, 4, carry width, passed through untouched.
- MXCNTB, 16, pre-trigger counter width.

Ports:
- clock  in  1  main clock.
- reset_n  in  1  asynchronous active-low reset.
- best_pat  in  MXPATB  sorter pattern word, valid every clock.
- best_key  in  MXKEYB  sorter key.
- best_carry  in  MXPATC  sorter carry.
- hit_thresh  in  3  minimum best_pat[6:4] to qualify.
- pid_thresh  in  4  minimum best_pat[3:0] to qualify.
- drift_delay  in  4  extra drift cycles after the first DRIFT cycle.
- dead_time  in  4  dead cycles after emit.
- cnt_clear  in  1  synchronous clear of pretrig_cnt.
- pretrig  out  1  one-cycle pulse on candidate acceptance.
- busy  out  1  high in DRIFT or DEAD.
- clct_vld  out  1  one-cycle emit pulse.
- clct_pat  out  MXPATB  held pattern.
- clct_key  out  MXKEYB  held key.
- clct_carry  out  MXPATC  held carry.
- pretrig_cnt  out  MXCNTB  saturating count of pretrig pulses.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All outputs and internal registers go to 0.
  - Asserting reset mid-DRIFT or mid-DEAD aborts with no emit.
  - Operation resumes in IDLE on the first clock edge after reset is released.
- Qualify rule: best_pat[6:4] >= hit_thresh AND best_pat[3:0] >= pid_thresh. Both comparisons are unsigned.
- IDLE:
  - When the input qualifies at edge t: latch pat/key/carry, load cnt=drift_delay, enter DRIFT.
  - pretrig=1 during cycle t+1 only.
  - Non-qualifying input: stay in IDLE.
- DRIFT, evaluated every cycle:
  - Update the held values if best_key == held key AND best_pat[6:1] > held pat[6:1] (strict; bit 0 is ignored).
  - Equal, worse, or different-key inputs are ignored. Thresholds are not re-applied.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: next cycle drive clct_vld=1 with the held values, including any update made in this last cycle.
    - If dead_time != 0: go to DEAD with cnt=dead_time.
    - If dead_time == 0: go to IDLE.
- Latency: clct_vld is asserted at cycle t+2+drift_delay, where t is the qualify edge.
- DEAD:
  - Lasts exactly dead_time cycles, counting the clct_vld cycle as the first.
  - Inputs are ignored; no pretrig is possible.
  - The first IDLE cycle may qualify a new candidate.
  - With dead_time=0 the emit cycle is itself IDLE, so a qualifying input on that cycle starts a new pretrig (back-to-back operation).
- Output holding:
  - clct_pat, clct_key and clct_carry are registered and change only when clct_vld is asserted.
  - They hold their value between emits.
- busy is registered and high for every DRIFT and DEAD cycle.
- Config sampling: drift_delay is sampled only on IDLE→DRIFT, dead_time only on DRIFT→DEAD. Mid-window changes have no effect on the current window.
- pretrig_cnt:
  - Increments on each pretrig pulse and saturates at 2^MXCNTB-1.
  - cnt_clear has priority: when cnt_clear and pretrig coincide, the result is 0.

Test Plan:
- Basic emit:
  - Config: hit_thresh=4, pid_thresh=2, drift_delay=2, dead_time=3.
  - Stimulus: best_pat=7'b101_0110, key=9, carry=4'hA for one cycle at edge t, zero after.
  - Expected: pretrig at t+1; clct_vld at t+4 with pat 0x56, key 9, carry A; busy high t+1..t+6.
- Drift upgrade:
  - Same config and initial candidate as basic emit.
  - Stimulus: at t+2 present key 9 with pat 7'b110_1000; at t+3 key 9 with 7'b110_1001 (differs only in bit 0); at t+3 also try key 10 with pat 7'b111_1010.
  - Expected: emitted pat 0x68, key 9.
- Thresholds:
  - Config: hit_thresh=4, pid_thresh=2.
  - Stimulus: pat 7'b011_1111, then pat 7'b111_0001.
  - Expected: no pretrig for either. Then pat 7'b100_0010 produces a pretrig.
- Back-to-back with no dead time:
  - Config: drift_delay=0, dead_time=0; qualifying input held constant for 10 cycles.
  - Expected: pretrig and clct_vld alternate every cycle from t+1; pretrig_cnt=5 after 10 cycles.
- Dead-time blocking:
  - Config: dead_time=3.
  - Stimulus: qualifying input held constant.
  - Expected: no pretrig during the 3 DEAD cycles; next pretrig exactly one cycle after the first IDLE cycle.
- Reset and counter:
  - Stimulus: drop reset_n mid-DRIFT.
  - Expected: outputs go to 0 immediately and clct_vld never fires.
  - Counter check: force pretrig_cnt to 0xFFFF and trigger; it stays at 0xFFFF. Assert cnt_clear concurrently with a pretrig; the count goes to 0.
